exe_stage: RTL
==============

Name: exe_stage

Overview:
- Execute stage of the 5-stage ARM pipeline; consumes everything the ID/EXE pipeline register emits.
- Generates the second ALU operand (Val2), runs the ALU, computes the branch target and owns the NZCV status register.
- Registers its results into the EXE/MEM boundary, so this block is both the EXE logic and the EXE_reg.
- Drives branch_taken back to IF and to the ID/EXE register's flush input.

Parameters:
- DATA_W, 32, datapath width (fixed by the ISA; parameterised for lint only).
- REG_AW, 4, register-file address width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- freeze  in  1  hazard stall; holds EXE/MEM outputs and SR.
- wb_en_in, mem_r_en_in, mem_w_en_in, b_in, s_in  in  1 each  control bits from ID/EXE.
- pc_in  in  DATA_W  PC+4 of the instruction.
- exe_cmd_in  in  4  ALU command.
- val_rn_in, val_rm_in  in  DATA_W  register operands.
- imm_in  in  1  I bit.
- shift_operand_in  in  12  ARM shifter operand.
- signed_imm_24_in  in  24  branch offset.
- dest_in  in  REG_AW  writeback register.
- branch_taken  out  1  combinational, equals b_in.
- branch_addr  out  DATA_W  combinational branch target.
- status  out  4  registered NZCV {N,Z,C,V}, to ID condition check.
- wb_en, mem_r_en, mem_w_en  out  1  registered, to MEM.
- alu_res  out  DATA_W  registered ALU result / memory address.
- st_val  out  DATA_W  registered store data (val_rm_in).
- dest  out  REG_AW  registered destination.

Behaviour:
- Reset: every registered output = 0 and status = 4'b0000, on the first clk edge with rst=1. Reset dominates freeze.
- Latency: 1 cycle from inputs to registered outputs. branch_taken and branch_addr are combinational (0 cycles).
- Val2 selection:
  - imm_in=1: {24'b0, shift_operand_in[7:0]} rotated right by 2*shift_operand_in[11:8].
  - Else if mem_r_en_in or mem_w_en_in: sign-extended shift_operand_in[11:0].
  - Else: val_rm_in shifted by shift_operand_in[11:7], using type [6:5]: 00 LSL, 01 LSR, 10 ASR, 11 ROR. A shift amount of 0 passes the value through unchanged.
- exe_cmd encoding:
  - 0001 MOV = Val2; 1001 MVN = ~Val2.
  - 0010 ADD/LDR/STR = Rn+Val2; 0011 ADC = Rn+Val2+C.
  - 0100 SUB/CMP = Rn−Val2; 0101 SBC = Rn−Val2−!C.
  - 0110 AND/TST; 0111 ORR; 1000 EOR.
  - Any other code gives result 0 and leaves flags C and V at 0.
- Flags:
  - N = res[31]; Z = (res==0).
  - Add: C = carry-out of the 33-bit sum; V = operands have the same sign and the result sign differs.
  - Subtract: C = NOT borrow; V = operands have different signs and the result sign differs from Rn.
  - Logical ops and MOV/MVN: C=0, V=0.
- SR update: status <= flags on posedge when s_in=1 and freeze=0; otherwise it holds. ADC/SBC read the pre-update C. SR updates regardless of b_in.
- Branch: branch_addr = pc_in + (sign_extend(signed_imm_24_in) << 2), with 32-bit wrap-around.
- EXE/MEM register:
  - freeze=1: all outputs hold.
  - Otherwise, capture wb_en_in, mem_r_en_in, mem_w_en_in, alu_res, val_rm_in, dest_in.
- Idle/bubble: an all-zero input bundle (flushed ID/EXE) must produce all-zero control outputs and no SR change.

Optional Feature:
- FORWARDING_EN defined:
  - Adds ports sel_src1 and sel_src2 (in, 2 bits each), mem_fwd_val (in, DATA_W) and wb_fwd_val (in, DATA_W).
  - Operand muxes: 00 = register value, 01 = mem_fwd_val, 10 = wb_fwd_val, 11 = register value.
  - Rn and Rm (including st_val) use the muxed values.
- FORWARDING_EN undefined: those ports are absent and the operands are taken straight from val_rn_in / val_rm_in.

Decomposition:
- Package arm_pkg holds:
  - the exe_cmd localparams (CMD_MOV … CMD_EOR);
  - the shift-type constants (SH_LSL, SH_LSR, SH_ASR, SH_ROR);
  - the NZCV bit indices.
- One sub-module, exe_alu: combinational, taking cmd, a, b and cin and returning res and nzcv.
- Val2 generation and the registers stay in exe_stage.

Test Plan:
- ADD with S: Rn=0x7FFFFFFF, imm_in=1, shift_operand=0x001, s_in=1 -> next cycle alu_res=0x80000000, status=4'b1001 (N,V).
- SUB/CMP: Rn=5, Rm=5, exe_cmd=0100, s_in=1, shift_operand=0 -> alu_res=0, status=4'b0110 (Z,C).
- Immediate rotate: imm_in=1, shift_operand=0x4FF, MOV -> alu_res=0xFF000000. Register ASR: Rm=0x80000000, shift_operand={5'd4,2'b10,1'b0,4'd0} -> alu_res=0xF8000000.
- LDR offset: mem_r_en_in=1, Rn=0x100, shift_operand=0xFFC -> alu_res=0xFC, mem_r_en=1.
- Branch: b_in=1, pc_in=0x20, imm24=0xFFFFFE -> branch_taken=1, branch_addr=0x18 in the same cycle.
- Freeze/reset: freeze=1 with s_in=1 -> outputs and status unchanged. rst=1 together with freeze=1 -> all outputs 0 next edge.

Source files
------------

// File: rtl/arm_pkg.sv
// Shared constants for the ARM execute stage: ALU command codes, shifter
// types, NZCV bit positions and a 32-bit rotate helper.
package arm_pkg;

  localparam logic [3:0] CMD_MOV = 4'b0001;
  localparam logic [3:0] CMD_ADD = 4'b0010;
  localparam logic [3:0] CMD_ADC = 4'b0011;
  localparam logic [3:0] CMD_SUB = 4'b0100;
  localparam logic [3:0] CMD_SBC = 4'b0101;
  localparam logic [3:0] CMD_AND = 4'b0110;
  localparam logic [3:0] CMD_ORR = 4'b0111;
  localparam logic [3:0] CMD_EOR = 4'b1000;
  localparam logic [3:0] CMD_MVN = 4'b1001;

  localparam logic [1:0] SH_LSL = 2'b00;
  localparam logic [1:0] SH_LSR = 2'b01;
  localparam logic [1:0] SH_ASR = 2'b10;
  localparam logic [1:0] SH_ROR = 2'b11;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  // Rotate right via a doubled word so a zero amount needs no special case.
  function automatic logic [31:0] ror32(input logic [31:0] x, input logic [4:0] r);
    logic [63:0] t;
    t = {x, x} >> r;
    return t[31:0];
  endfunction

endpackage

// File: rtl/exe_alu.sv
// Combinational ALU for the execute stage; produces the result and NZCV.
module exe_alu
  import arm_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [3:0]        cmd_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  logic              cin_i,
  output logic [DATA_W-1:0] res_o,
  output logic [3:0]        nzcv_o
);

  localparam int MSB = DATA_W - 1;

  logic [DATA_W:0]   sum_s;
  logic [DATA_W-1:0] res_s;
  logic              c_s;
  logic              v_s;

  // Subtraction is a + ~b + 1 (or + C for SBC), so carry-out is NOT borrow.
  always_comb begin
    sum_s = '0;
    res_s = '0;
    c_s   = 1'b0;
    v_s   = 1'b0;
    case (cmd_i)
      CMD_MOV: res_s = b_i;
      CMD_MVN: res_s = ~b_i;
      CMD_ADD, CMD_ADC: begin
        sum_s = {1'b0, a_i} + {1'b0, b_i}
              + {{DATA_W{1'b0}}, (cmd_i == CMD_ADC) ? cin_i : 1'b0};
        res_s = sum_s[DATA_W-1:0];
        c_s   = sum_s[DATA_W];
        v_s   = (a_i[MSB] == b_i[MSB]) && (res_s[MSB] != a_i[MSB]);
      end
      CMD_SUB, CMD_SBC: begin
        sum_s = {1'b0, a_i} + {1'b0, ~b_i}
              + {{DATA_W{1'b0}}, (cmd_i == CMD_SBC) ? cin_i : 1'b1};
        res_s = sum_s[DATA_W-1:0];
        c_s   = sum_s[DATA_W];
        v_s   = (a_i[MSB] != b_i[MSB]) && (res_s[MSB] != a_i[MSB]);
      end
      CMD_AND: res_s = a_i & b_i;
      CMD_ORR: res_s = a_i | b_i;
      CMD_EOR: res_s = a_i ^ b_i;
      default: res_s = '0;
    endcase
  end

  assign res_o  = res_s;
  assign nzcv_o = {res_s[MSB], (res_s == '0), c_s, v_s};

endmodule

// File: rtl/exe_stage.sv
// ARM execute stage plus EXE/MEM register and NZCV status register.
// Optional operand forwarding muxes are enabled by defining FORWARDING_EN.
module exe_stage
  import arm_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              freeze,
  input  logic              wb_en_in,
  input  logic              mem_r_en_in,
  input  logic              mem_w_en_in,
  input  logic              b_in,
  input  logic              s_in,
  input  logic [DATA_W-1:0] pc_in,
  input  logic [3:0]        exe_cmd_in,
  input  logic [DATA_W-1:0] val_rn_in,
  input  logic [DATA_W-1:0] val_rm_in,
  input  logic              imm_in,
  input  logic [11:0]       shift_operand_in,
  input  logic [23:0]       signed_imm_24_in,
  input  logic [REG_AW-1:0] dest_in,
`ifdef FORWARDING_EN
  input  logic [1:0]        sel_src1,
  input  logic [1:0]        sel_src2,
  input  logic [DATA_W-1:0] mem_fwd_val,
  input  logic [DATA_W-1:0] wb_fwd_val,
`endif
  output logic              branch_taken,
  output logic [DATA_W-1:0] branch_addr,
  output logic [3:0]        status,
  output logic              wb_en,
  output logic              mem_r_en,
  output logic              mem_w_en,
  output logic [DATA_W-1:0] alu_res,
  output logic [DATA_W-1:0] st_val,
  output logic [REG_AW-1:0] dest
);

  logic [DATA_W-1:0] rn_s;
  logic [DATA_W-1:0] rm_s;
  logic [DATA_W-1:0] val2_s;
  logic [DATA_W-1:0] alu_res_s;
  logic [3:0]        nzcv_s;
  logic [4:0]        sh_amt_s;

  logic              wb_en_q, mem_r_en_q, mem_w_en_q;
  logic [DATA_W-1:0] alu_res_q, st_val_q;
  logic [REG_AW-1:0] dest_q;
  logic [3:0]        status_q, status_d;

`ifdef FORWARDING_EN
  // Operand forwarding: 01 selects MEM, 10 selects WB, else register file.
  always_comb begin
    case (sel_src1)
      2'b01:   rn_s = mem_fwd_val;
      2'b10:   rn_s = wb_fwd_val;
      default: rn_s = val_rn_in;
    endcase
    case (sel_src2)
      2'b01:   rm_s = mem_fwd_val;
      2'b10:   rm_s = wb_fwd_val;
      default: rm_s = val_rm_in;
    endcase
  end
`else
  assign rn_s = val_rn_in;
  assign rm_s = val_rm_in;
`endif

  assign sh_amt_s = shift_operand_in[11:7];

  // Val2: rotated immediate, sign-extended memory offset, or shifted Rm.
  always_comb begin
    if (imm_in) begin
      val2_s = ror32({24'd0, shift_operand_in[7:0]}, {shift_operand_in[11:8], 1'b0});
    end else if (mem_r_en_in || mem_w_en_in) begin
      val2_s = {{20{shift_operand_in[11]}}, shift_operand_in};
    end else begin
      case (shift_operand_in[6:5])
        SH_LSL:  val2_s = rm_s << sh_amt_s;
        SH_LSR:  val2_s = rm_s >> sh_amt_s;
        SH_ASR:  val2_s = $unsigned($signed(rm_s) >>> sh_amt_s);
        SH_ROR:  val2_s = ror32(rm_s, sh_amt_s);
        default: val2_s = rm_s;
      endcase
    end
  end

  exe_alu #(.DATA_W(DATA_W)) u_alu (
    .cmd_i  (exe_cmd_in),
    .a_i    (rn_s),
    .b_i    (val2_s),
    .cin_i  (status_q[FLAG_C]),
    .res_o  (alu_res_s),
    .nzcv_o (nzcv_s)
  );

  assign branch_taken = b_in;
  assign branch_addr  = pc_in + {{6{signed_imm_24_in[23]}}, signed_imm_24_in, 2'b00};

  // Next status: load flags only for S-bit instructions.
  always_comb begin
    if (s_in) begin
      status_d = nzcv_s;
    end else begin
      status_d = status_q;
    end
  end

  // EXE/MEM pipeline register and status register; freeze holds everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_en_q    <= 1'b0;
      mem_r_en_q <= 1'b0;
      mem_w_en_q <= 1'b0;
      alu_res_q  <= '0;
      st_val_q   <= '0;
      dest_q     <= '0;
      status_q   <= 4'b0000;
    end else if (!freeze) begin
      wb_en_q    <= wb_en_in;
      mem_r_en_q <= mem_r_en_in;
      mem_w_en_q <= mem_w_en_in;
      alu_res_q  <= alu_res_s;
      st_val_q   <= rm_s;
      dest_q     <= dest_in;
      status_q   <= status_d;
    end
  end

  assign wb_en    = wb_en_q;
  assign mem_r_en = mem_r_en_q;
  assign mem_w_en = mem_w_en_q;
  assign alu_res  = alu_res_q;
  assign st_val   = st_val_q;
  assign dest     = dest_q;
  assign status   = status_q;

endmodule
